// File: rtl/booth_mul_if.sv
// Operand/result bundle for booth_mul; busy is carried only when BOOTH_MUL_BUSY_EN is defined.
interface booth_mul_if #(
  parameter int WIDTH = 4
);
  logic                      start;
  logic signed [WIDTH-1:0]   X;
  logic signed [WIDTH-1:0]   Y;
  logic                      valid;
  logic signed [2*WIDTH-1:0] Z;
`ifdef BOOTH_MUL_BUSY_EN
  logic                      busy;
`endif

  modport master (
    output start, X, Y,
`ifdef BOOTH_MUL_BUSY_EN
    input  busy,
`endif
    input  valid, Z
  );

  modport slave (
    input  start, X, Y,
`ifdef BOOTH_MUL_BUSY_EN
    output busy,
`endif
    output valid, Z
  );
endinterface

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth signed multiplier, WIDTH cycles from accepted start to valid; start is ignored while BUSY.
// Optional registered busy output when BOOTH_MUL_BUSY_EN is defined.
module booth_mul #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  booth_mul_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH:0]      a_q, a_d;
  logic [WIDTH:0]      m_q, m_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                q1_q, q1_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  z_q, z_d;
  logic                valid_q, valid_d;

  logic [WIDTH:0]      sum;
  logic [2*WIDTH+1:0]  shifted;

  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    // Arithmetic shift of {A,Q,Q_1}: replicate A's sign bit, drop Q_1.
    shifted = {sum[WIDTH], sum, q_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = {bus.X[WIDTH-1], bus.X};
          a_d     = '0;
          q_d     = bus.Y;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          valid_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = shifted[2*WIDTH+1:WIDTH+1];
        q_d   = shifted[WIDTH:1];
        q1_d  = shifted[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = shifted[2*WIDTH:1];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Z     = z_q;
  assign bus.valid = valid_q;

`ifdef BOOTH_MUL_BUSY_EN
  logic busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= 1'b0;
    else      busy_q <= (state_d == BUSY);
  end

  assign bus.busy = busy_q;
`endif
endmodule

// File: tb/tb_booth_mul.sv
// Directed bench for booth_mul: reset, latency, back-to-back, corner operands, ignored start, mid-op reset.
module tb_booth_mul;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  booth_mul_if #(.WIDTH(W)) bus();

  booth_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: start sampled at the next posedge (edge k); returns at k+1ns.
  task automatic pulse_start(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    @(negedge clk);
    bus.X     = x;
    bus.Y     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = (i % 2 == 0);
      bus.X     = 4'sd5;
      bus.Y     = 4'sd3;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b0 || bus.Z !== 8'sd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: valid=%b Z=%0d expected valid=0 Z=0", i, bus.valid, bus.Z);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b0 || bus.Z !== 8'sd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: valid=%b Z=%0d expected valid=0 Z=0", i, bus.valid, bus.Z);
      end
    end
  endtask

  task automatic test_basic();
    logic signed [2*W-1:0] exp_z;
    exp_z = 8'sd35;
    pulse_start(4'sd5, 4'sd7);
`ifdef BOOTH_MUL_BUSY_EN
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_on: busy=%b expected 1", bus.busy);
    end
`endif
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early_valid[k+%0d]: valid=%b expected 0", i, bus.valid);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b1 || bus.Z !== exp_z) begin
      n_fail++;
      $display("FAIL basic_done: valid=%b Z=%0d expected valid=1 Z=%0d", bus.valid, bus.Z, exp_z);
    end
`ifdef BOOTH_MUL_BUSY_EN
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_off: busy=%b expected 0", bus.busy);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b1 || bus.Z !== exp_z) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: valid=%b Z=%0d expected valid=1 Z=%0d", i, bus.valid, bus.Z, exp_z);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(-4'sd4, 4'sd6);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.Z !== 8'sd35) begin
      n_fail++;
      $display("FAIL b2b_drop: valid=%b Z=%0d expected valid=0 Z=35", bus.valid, bus.Z);
    end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_early_valid[k+%0d]: valid=%b expected 0", i, bus.valid);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b1 || bus.Z !== -8'sd24) begin
      n_fail++;
      $display("FAIL b2b_done: valid=%b Z=%0d expected valid=1 Z=-24", bus.valid, bus.Z);
    end
  endtask

  task automatic test_corners();
    int                    cx[4] = '{-8, -8, 7, 0};
    int                    cy[4] = '{-8, 7, -1, -5};
    int                    cz[4] = '{64, -56, -7, 0};
    logic signed [2*W-1:0] exp_z;
    for (int t = 0; t < 4; t++) begin
      exp_z = 8'(cz[t]);
      pulse_start(4'(cx[t]), 4'(cy[t]));
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b1 || bus.Z !== exp_z) begin
        n_fail++;
        $display("FAIL corner[%0d] %0d*%0d: valid=%b Z=%0d expected valid=1 Z=%0d",
                 t, cx[t], cy[t], bus.valid, bus.Z, exp_z);
      end
    end
  endtask

  task automatic test_start_ignored();
    pulse_start(4'sd3, 4'sd3);
    @(posedge clk);
    #1;
    bus.X     = 4'sd1;
    bus.Y     = 4'sd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_early_valid: valid=%b expected 0", bus.valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b1 || bus.Z !== 8'sd9) begin
      n_fail++;
      $display("FAIL ignore_done: valid=%b Z=%0d expected valid=1 Z=9", bus.valid, bus.Z);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b1 || bus.Z !== 8'sd9) begin
      n_fail++;
      $display("FAIL ignore_hold: valid=%b Z=%0d expected valid=1 Z=9", bus.valid, bus.Z);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(4'sd5, 4'sd7);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.valid !== 1'b0 || bus.Z !== 8'sd0) begin
      n_fail++;
      $display("FAIL midrst_abort: valid=%b Z=%0d expected valid=0 Z=0", bus.valid, bus.Z);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.valid !== 1'b0 || bus.Z !== 8'sd0) begin
        n_fail++;
        $display("FAIL midrst_idle[%0d]: valid=%b Z=%0d expected valid=0 Z=0", i, bus.valid, bus.Z);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_corners();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
